// File: rtl/ls194_pkg.sv
// ls194_pkg: mode, op-code and state encodings shared by the ls74194 chain sequencer
package ls194_pkg;
  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_SHR  = 2'b01;
  localparam logic [1:0] S_SHL  = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;
endpackage

// File: rtl/ls194_shift_ctrl.sv
// ls194_shift_ctrl: sequences one load/shift/rotate request onto a cascaded ls74194 chain
module ls194_shift_ctrl
  import ls194_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic             q_msb,
  input  logic             q_lsb,
  output logic [1:0]       s,
  output logic             sil,
  output logic             sir,
  output logic             busy,
  output logic             done
);
  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             shifting, is_shift_op;
  assign is_shift_op = (op >= OP_SHL) && (op <= OP_ASR);
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_LOAD) state_d = ST_LOAD;
          else if (is_shift_op && amount != '0) begin
            state_d = ST_SHIFT;
            op_d    = op;
            cnt_d   = amount;
          end else state_d = ST_DONE;
        end
      end
      ST_LOAD: state_d = ST_DONE;
      ST_SHIFT: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CNT_W'(1)) ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end
  // outputs decode only from registered state so start never reaches them combinationally
  assign shifting = state_q == ST_SHIFT;
  assign s = (state_q == ST_LOAD) ? S_LOAD
           : !shifting ? S_HOLD
           : (op_q == OP_SHL || op_q == OP_ROL) ? S_SHL : S_SHR;
  assign sil  = shifting && op_q == OP_ROL && q_msb;
  assign sir  = shifting && ((op_q == OP_ROR && q_lsb) || (op_q == OP_ASR && q_msb));
  assign busy = state_q != ST_IDLE;
  assign done = state_q == ST_DONE;
endmodule

// File: tb/tb_ls194_shift_ctrl.sv
// tb_ls194_shift_ctrl: drives ls194_shift_ctrl into a behavioural 8-bit ls74194 chain
module tb_ls194_shift_ctrl;
  logic       clk = 0, clear_n = 0, start = 0;
  logic [2:0] op = 0;
  logic [3:0] amount = 0;
  logic [1:0] s;
  logic       sil, sir, busy, done;
  logic [7:0] chain_q = 8'h00, p = 8'h00;
  int tests = 0, fails = 0;
  int bc, ac, dc, dat;
  logic [1:0] sor;
  bit tmo;
  logic [7:0] exp_q;

  ls194_shift_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .clear_n(clear_n), .start(start), .op(op), .amount(amount),
    .q_msb(chain_q[7]), .q_lsb(chain_q[0]), .s(s), .sil(sil), .sir(sir),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // chain load: not cleared by clear_n, keeps partial results
  always @(posedge clk) begin
    case (s)
      2'b01: chain_q <= {sir, chain_q[7:1]};
      2'b10: chain_q <= {chain_q[6:0], sil};
      2'b11: chain_q <= p;
      default: ;
    endcase
  end

  function automatic logic [7:0] ref_shift(input logic [2:0] o, input int a, input logic [7:0] v);
    logic [15:0] w;
    int r;
    w = {v, v};
    r = a % 8;
    case (o)
      3'd2: return v << a;
      3'd3: return v >> a;
      3'd4: begin w = w << r; return w[15:8]; end
      3'd5: begin w = w >> r; return w[7:0]; end
      3'd6: return 8'($signed(v) >>> a);
      default: return v;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [3:0] a, input bit poke);
    int n;
    bc = 0; ac = 0; dc = 0; dat = -1; sor = 0; tmo = 0; n = 0;
    @(negedge clk);
    start = 1; op = o; amount = a;
    @(negedge clk);
    start = 0;
    while (busy && n < 40) begin
      if (s != 2'b00) begin ac++; sor |= s; end
      if (done) begin dc++; dat = bc; end
      bc++;
      if (poke && n == 1) begin start = 1; op = 3'b001; amount = 4'd7; end
      else if (poke && n == 2) start = 0;
      @(negedge clk);
      n++;
    end
    start = 0;
    tmo = n >= 40;
  endtask

  task automatic load_chain(input logic [7:0] v);
    p = v;
    run_op(3'b001, 4'd0, 0);
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++; if ({s, busy, done} !== 4'b0000) begin fails++; $display("FAIL reset_state got s=%b busy=%b done=%b want 00 0 0", s, busy, done); end
    clear_n = 1;
    load_chain(8'hF0);
    @(negedge clk);
    start = 1; op = 3'b010; amount = 4'd5;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    clear_n = 0;
    #1;
    tests++; if ({s, busy, done} !== 4'b0000) begin fails++; $display("FAIL reset_abort got s=%b busy=%b done=%b want 00 0 0", s, busy, done); end
    tests++; if (chain_q !== 8'hC0) begin fails++; $display("FAIL reset_partial got %h want c0", chain_q); end
    repeat (2) @(negedge clk);
    clear_n = 1;
    dc = 0; bc = 0;
    repeat (10) begin @(negedge clk); dc += done; bc += busy; end
    tests++; if (dc !== 0 || bc !== 0) begin fails++; $display("FAIL reset_no_done got done=%0d busy=%0d want 0 0", dc, bc); end
  endtask

  task automatic test_load;
    load_chain(8'hA5);
    tests++; if (bc !== 2 || ac !== 1 || sor !== 2'b11) begin fails++; $display("FAIL load_timing got busy=%0d act=%0d s=%b want 2 1 11", bc, ac, sor); end
    tests++; if (dc !== 1 || dat !== 1) begin fails++; $display("FAIL load_done got n=%0d at=%0d want 1 1", dc, dat); end
    tests++; if (chain_q !== 8'hA5) begin fails++; $display("FAIL load_q got %h want a5", chain_q); end
  endtask

  task automatic test_shl;
    load_chain(8'hA5);
    run_op(3'b010, 4'd3, 0);
    tests++; if (bc !== 4 || ac !== 3 || sor !== 2'b10) begin fails++; $display("FAIL shl_timing got busy=%0d act=%0d s=%b want 4 3 10", bc, ac, sor); end
    tests++; if (dc !== 1 || dat !== 3) begin fails++; $display("FAIL shl_done got n=%0d at=%0d want 1 3", dc, dat); end
    tests++; if (chain_q !== 8'h28) begin fails++; $display("FAIL shl_q got %h want 28", chain_q); end
  endtask

  task automatic test_rotate_asr;
    load_chain(8'hA5); run_op(3'b101, 4'd4, 0);
    tests++; if (chain_q !== 8'h5A) begin fails++; $display("FAIL ror_q got %h want 5a", chain_q); end
    load_chain(8'h85); run_op(3'b110, 4'd2, 0);
    tests++; if (chain_q !== 8'hE1) begin fails++; $display("FAIL asr_q got %h want e1", chain_q); end
    load_chain(8'h3C); run_op(3'b100, 4'd8, 0);
    tests++; if (chain_q !== 8'h3C || bc !== 9) begin fails++; $display("FAIL rol8 got q=%h busy=%0d want 3c 9", chain_q, bc); end
  endtask

  task automatic test_random;
    logic [2:0] o;
    logic [3:0] a;
    logic [7:0] v;
    for (int i = 0; i < 25; i++) begin
      o = 3'($urandom_range(6, 2));
      a = 4'($urandom_range(15, 0));
      v = 8'($urandom);
      load_chain(v);
      run_op(o, a, 0);
      exp_q = ref_shift(o, int'(a), v);
      tests++; if (chain_q !== exp_q || tmo) begin fails++; $display("FAIL rand_q op=%0d amt=%0d in=%h got %h want %h", o, a, v, chain_q, exp_q); end
      tests++; if (bc !== (a == 0 ? 1 : int'(a) + 1) || ac !== int'(a) || dc !== 1) begin fails++; $display("FAIL rand_timing op=%0d amt=%0d got busy=%0d act=%0d done=%0d", o, a, bc, ac, dc); end
    end
  endtask

  task automatic test_zero_and_busy;
    load_chain(8'h96);
    run_op(3'b011, 4'd0, 0);
    tests++; if (bc !== 1 || ac !== 0 || dc !== 1 || dat !== 0) begin fails++; $display("FAIL shr0 got busy=%0d act=%0d done=%0d want 1 0 1", bc, ac, dc); end
    tests++; if (chain_q !== 8'h96) begin fails++; $display("FAIL shr0_q got %h want 96", chain_q); end
    p = 8'h00;
    run_op(3'b010, 4'd3, 1);
    tests++; if (bc !== 4 || ac !== 3 || sor !== 2'b10 || dc !== 1) begin fails++; $display("FAIL busy_ignore got busy=%0d act=%0d s=%b done=%0d want 4 3 10 1", bc, ac, sor, dc); end
    tests++; if (chain_q !== 8'hB0) begin fails++; $display("FAIL busy_ignore_q got %h want b0", chain_q); end
    run_op(3'b000, 4'd0, 0);
    tests++; if (bc !== 1 || ac !== 0 || dc !== 1) begin fails++; $display("FAIL nop got busy=%0d act=%0d done=%0d want 1 0 1", bc, ac, dc); end
  endtask

  task automatic test_reserved;
    load_chain(8'h5C);
    run_op(3'b111, 4'd4, 0);
    tests++; if (bc !== 1 || ac !== 0 || dc !== 1) begin fails++; $display("FAIL rsvd got busy=%0d act=%0d done=%0d want 1 0 1", bc, ac, dc); end
    tests++; if (chain_q !== 8'h5C) begin fails++; $display("FAIL rsvd_q got %h want 5c", chain_q); end
  endtask

  initial begin
    test_reset;
    test_load;
    test_shl;
    test_rotate_asr;
    test_random;
    test_zero_and_busy;
    test_reserved;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
